// File: rtl/octave_detect.sv
// Octave detector: measures the period of a divided clock (clk/2^(octave+2)) and reports octave + lock.
// Optional macro OCTAVE_DETECT_TIMEOUT_EN: drop back to IDLE with a timeout pulse when the counter saturates.
module octave_detect #(
  parameter int CNT_W       = 10,
  parameter int LOCK_COUNT  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div_in,
  output logic [2:0] octave,
  output logic       locked,
  output logic       sample_vld,
  output logic       err,
  output logic       timeout
);

  localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]          match_q, match_d;
  logic [2:0]             last_q, last_d;
  logic [2:0]             octave_q, octave_d;
  logic                   locked_q, locked_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;
  logic                   rise;
  logic                   p_valid;
  logic [2:0]             p_cand;
  logic [MW-1:0]          new_match;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [MW-1:0] match_inc(input logic [MW-1:0] m);
    return (m >= MATCH_MAX) ? MATCH_MAX : m + 1'b1;
  endfunction

  // Returns {valid, log2(p)-2}; valid only for exact powers of two 4..512.
  function automatic logic [3:0] decode_period(input logic [CNT_W-1:0] p);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (p == CNT_W'(4 << i)) r = {1'b1, 3'(i)};
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise                = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign {p_valid, p_cand}   = decode_period(cnt_q);
  assign new_match           = (p_cand == last_q) ? match_inc(match_q) : MW'(1);

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    last_d   = last_q;
    octave_d = octave_q;
    locked_d = locked_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    cnt_d    = rise ? CNT_W'(1) : cnt_inc(cnt_q);
    case (state_q)
      IDLE: begin
        if (rise) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (rise) begin
          vld_d = 1'b1;
          if (!p_valid) begin
            err_d   = 1'b1;
            match_d = '0;
          end else begin
            last_d  = p_cand;
            match_d = new_match;
            if (new_match == MATCH_MAX) begin
              octave_d = p_cand;
              locked_d = 1'b1;
              state_d  = LOCKED;
            end
          end
        end
`ifdef OCTAVE_DETECT_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
`endif
      end
      LOCKED: begin
        if (rise) begin
          vld_d = 1'b1;
          if (!p_valid) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = ACQUIRE;
          end else if (p_cand != octave_q) begin
            locked_d = 1'b0;
            last_d   = p_cand;
            match_d  = MW'(1);
            state_d  = ACQUIRE;
          end
        end
`ifdef OCTAVE_DETECT_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      last_q   <= '0;
      octave_q <= '0;
      locked_q <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      last_q   <= last_d;
      octave_q <= octave_d;
      locked_q <= locked_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign octave     = octave_q;
  assign locked     = locked_q;
  assign sample_vld = vld_q;
  assign err        = err_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_octave_detect.sv
// Scoreboard bench for octave_detect: directed period sequences with hand-computed results.
// Expectations for the saturation case follow OCTAVE_DETECT_TIMEOUT_EN when it is defined.
module tb_octave_detect;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       div_in = 1'b0;
  logic [2:0] octave;
  logic       locked, sample_vld, err, timeout;

  typedef struct packed {
    logic       e;
    logic       l;
    logic [2:0] o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   tmo_seen = 0;

  octave_detect #(.CNT_W(10), .LOCK_COUNT(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .div_in(div_in), .octave(octave),
    .locked(locked), .sample_vld(sample_vld), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // One rise followed by a segment of len cycles; the expectation belongs to the
  // measurement taken at this rise (the length of the previous segment).
  task automatic seg(input int len, input bit chk, input logic e, input logic l,
                     input logic [2:0] o);
    exp_t x;
    if (chk) begin
      x.e = e; x.l = l; x.o = o;
      q.push_back(x);
    end
    div_in = 1'b1;
    repeat (len / 2) @(negedge clk);
    div_in = 1'b0;
    repeat (len - len / 2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (timeout) tmo_seen++;
      if (err && !sample_vld) begin
        tests++; fails++;
        $display("FAIL err_without_vld at %0t: err=%b sample_vld=%b", $time, err, sample_vld);
      end
      if (sample_vld) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_sample at %0t: got err=%b locked=%b octave=%0d, none expected",
                   $time, err, locked, octave);
        end else begin
          exp_t x;
          x = q.pop_front();
          if ({err, locked, octave} !== {x.e, x.l, x.o}) begin
            fails++;
            $display("FAIL sample at %0t: got err=%b locked=%b octave=%0d, want err=%b locked=%b octave=%0d",
                     $time, err, locked, octave, x.e, x.l, x.o);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    tests++;
    if ({octave, locked, sample_vld, err, timeout} !== 7'b0) begin
      fails++;
      $display("FAIL reset_state: got %b, want 0000000", {octave, locked, sample_vld, err, timeout});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Period 4: arm, then three matching measurements lock octave 0.
    seg(4, 0, 0, 0, 0);
    seg(4, 1, 0, 0, 0);
    seg(4, 1, 0, 0, 0);
    seg(4, 1, 0, 1, 0);
    seg(32, 1, 0, 1, 0);
    // Relock at 32 (octave 3), then switch to 128 (octave 5).
    seg(32, 1, 0, 0, 0);
    seg(32, 1, 0, 0, 0);
    seg(128, 1, 0, 1, 3);
    seg(128, 1, 0, 0, 3);
    seg(128, 1, 0, 0, 3);
    seg(16, 1, 0, 1, 5);
    // Lock at 16 (octave 2), one bad 6-cycle period, then relock.
    seg(16, 1, 0, 0, 5);
    seg(16, 1, 0, 0, 5);
    seg(6, 1, 0, 1, 2);
    seg(16, 1, 1, 0, 2);
    seg(16, 1, 0, 0, 2);
    seg(16, 1, 0, 0, 2);
    seg(16, 1, 0, 1, 2);
    seg(16, 1, 0, 1, 2);

    // Asynchronous reset between clock edges while locked.
    @(posedge clk);
    #2;
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_locked: got %b, want 1", locked);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({octave, locked, sample_vld, err, timeout} !== 7'b0) begin
      fails++;
      $display("FAIL async_reset: got %b, want 0000000", {octave, locked, sample_vld, err, timeout});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Re-acquire at period 4 from IDLE, then move to period 512 (octave 7).
    seg(4, 0, 0, 0, 0);
    seg(4, 1, 0, 0, 0);
    seg(4, 1, 0, 0, 0);
    seg(512, 1, 0, 1, 0);
    seg(512, 1, 0, 0, 0);
    seg(512, 1, 0, 0, 0);
    seg(512, 1, 0, 1, 7);
    seg(1100, 1, 0, 1, 7);

    // Gap of 1100 cycles overruns the 10-bit counter.
    tests++;
`ifdef OCTAVE_DETECT_TIMEOUT_EN
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL locked_after_timeout: got %b, want 0", locked);
    end
    seg(4, 0, 0, 0, 0);
`else
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL locked_during_saturation: got %b, want 1", locked);
    end
    seg(4, 1, 1, 0, 7);
`endif
    seg(4, 1, 0, 0, 7);
    repeat (5) @(negedge clk);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_samples: got %0d outstanding, want 0", q.size());
    end
    tests++;
`ifdef OCTAVE_DETECT_TIMEOUT_EN
    if (tmo_seen != 1) begin
`else
    if (tmo_seen != 0) begin
`endif
      fails++;
      $display("FAIL timeout_count: got %0d pulses", tmo_seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
